mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single external memory port (QSPI ROM/RAM controller) among up to N requesters.
- Default requesters: 0 = instruction/operand fetch from the control unit (PC-addressed), 1 = data RAM read/write, 2 = debug/loader.
- Round-robin arbitration, one outstanding transaction at a time.
- Per-transaction timeout so a hung memory controller cannot deadlock the CPU.

Parameters:
- N_REQ, 3, number of requesters (2..4).
- AW, 23, address width; matches the CU program counter width.
- DW, 8, data width.
- TIMEOUT, 255, maximum cycles to wait for mem_done before aborting; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- req  input  N_REQ  per-requester request level
- req_we  input  N_REQ  per-requester write enable (1 = write)
- req_addr  input  N_REQ*AW  packed addresses; requester i occupies bits [i*AW +: AW]
- req_wdata  input  N_REQ*DW  packed write data
- gnt  output  N_REQ  one-hot grant, held for the whole transaction
- done  output  N_REQ  one-cycle completion pulse to the owner
- err  output  N_REQ  one-cycle timeout pulse to the owner
- rdata  output  DW  read data, registered; valid in the done cycle and held until the next done
- mem_start  output  1  one-cycle start pulse to the memory controller
- mem_we  output  1  write flag, registered at grant
- mem_addr  output  AW  address, registered at grant
- mem_wdata  output  DW  write data, registered at grant
- mem_done  input  1  one-cycle completion pulse from the memory controller
- mem_rdata  input  DW  read data, valid while mem_done is high

Behaviour:
- Reset (asynchronous, any state): state=IDLE, rr_ptr=0, timer=0; gnt, done, err, rdata, mem_start, mem_we, mem_addr, mem_wdata all 0.
- IDLE:
  - If any req bit is set, choose the first set bit searching upward from rr_ptr with wrap-around.
  - Register gnt=onehot(i); latch mem_addr, mem_we and mem_wdata from slot i; set rr_ptr=(i+1) mod N_REQ.
  - Go to ISSUE.
- ISSUE:
  - mem_start=1 for exactly this cycle; timer=0.
  - Go to WAIT.
- WAIT:
  - Each cycle without mem_done: timer+1.
  - mem_done=1: rdata<=mem_rdata (reads only; writes leave rdata unchanged); go to RESP with done pulse pending.
  - timer reaches TIMEOUT with no mem_done (TIMEOUT>0): go to RESP with err pulse pending; rdata unchanged.
- RESP:
  - done[i]=1 (or err[i]=1) for exactly one cycle; gnt cleared at the end of RESP.
  - Go to IDLE.
- Latency: req sampled in cycle 0 → gnt visible in cycle 1 → mem_start in cycle 1 → earliest done in cycle 3, given mem_done in cycle 2. Minimum turnaround is 4 cycles per transaction.
- Requester obligations:
  - Hold req, req_we, req_addr and req_wdata stable from assertion until its done/err cycle.
  - Operands are latched at grant, so later changes are ignored but remain illegal.
  - req still high in the cycle after done is treated as a new request.
- Dropping req while granted: the transaction runs to completion; done/err is still pulsed to the original owner.
- mem_done outside WAIT is ignored; no rdata update.
- Simultaneous requests: the round-robin order guarantees each requester is served within N_REQ transactions.
- gnt is always one-hot or zero; done and err are never both high; at most one done/err bit is high.
- Timer width: clog2(TIMEOUT+1). The timer saturates and does not wrap.

Test Plan:
- Single read: req=3'b001, addr=0x000010; mem_done at 2nd WAIT cycle with mem_rdata=0xA5 → mem_start once with mem_addr=0x000010, mem_we=0; done=3'b001 one cycle; rdata=0xA5; gnt=0 afterwards.
- Write: req[1] with we=1, addr=0x400123, wdata=0x3C → mem_we=1, mem_wdata=0x3C; done[1] pulses; rdata keeps its prior value 0xA5.
- Contention: req=3'b111 held continuously, mem_done one cycle after start → grant order 0,1,2,0,1,2; rr_ptr wraps to 0 after requester 2.
- Timeout: TIMEOUT=8, req[2], mem_done never asserted → err=3'b100 exactly 8 WAIT cycles after mem_start; done stays 0; the next request is accepted normally.
- Reset mid-transaction: rst asserted in WAIT with gnt=3'b010 → all outputs 0 immediately; after release req[0] wins (rr_ptr=0); a stray mem_done in IDLE causes no done and no rdata change.
- Request withdrawn: req[1] dropped one cycle after grant → transaction completes; done[1] still pulses; no second mem_start.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port (QSPI ROM/RAM controller) among
// N_REQ requesters with round-robin arbitration, one transaction in flight, and
// a per-transaction timeout so a hung controller cannot stall the CPU.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_i             per-requester request level
//   req_we_i          per-requester write enable (1 = write)
//   req_addr_i        packed addresses, slot i at [i*AW +: AW]
//   req_wdata_i       packed write data, slot i at [i*DW +: DW]
//   gnt_o             one-hot grant, held for the whole transaction
//   done_o / err_o    one-cycle completion / timeout pulse to the owner
//   rdata_o           read data, updated on read completion, held otherwise
//   mem_start_o       one-cycle start pulse to the memory controller
//   mem_we_o, mem_addr_o, mem_wdata_o  operands latched at grant
//   mem_done_i        one-cycle completion pulse from the memory controller
//   mem_rdata_i       read data, valid while mem_done_i is high
module mem_arbiter #(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned AW      = 23,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ-1:0]    req_we_i,
    input  logic [N_REQ*AW-1:0] req_addr_i,
    input  logic [N_REQ*DW-1:0] req_wdata_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic [N_REQ-1:0]    done_o,
    output logic [N_REQ-1:0]    err_o,
    output logic [DW-1:0]       rdata_o,
    output logic                mem_start_o,
    output logic                mem_we_o,
    output logic [AW-1:0]       mem_addr_o,
    output logic [DW-1:0]       mem_wdata_o,
    input  logic                mem_done_i,
    input  logic [DW-1:0]       mem_rdata_i
);

    localparam int unsigned PtrW   = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam int unsigned TimerW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TimerW:0]  TimeoutLim = (TimerW + 1)'(TIMEOUT);
    localparam logic [PtrW-1:0]  LastIdx    = PtrW'(N_REQ - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q;
    logic [PtrW-1:0]     rr_q;
    logic [TimerW-1:0]   timer_q;
    logic [N_REQ-1:0]    gnt_q;
    logic [N_REQ-1:0]    done_q;
    logic [N_REQ-1:0]    err_q;
    logic [DW-1:0]       rdata_q;
    logic                mem_start_q;
    logic                mem_we_q;
    logic [AW-1:0]       mem_addr_q;
    logic [DW-1:0]       mem_wdata_q;

    logic                found;
    logic [PtrW-1:0]     pick;
    logic [PtrW-1:0]     cand;
    logic [PtrW-1:0]     rr_next;
    logic [N_REQ-1:0]    pick_onehot;
    logic                sel_we;
    logic [AW-1:0]       sel_addr;
    logic [DW-1:0]       sel_wdata;
    logic [TimerW:0]     timer_inc;

    // Rotating search: first set request at or above rr_q, wrapping to 0.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = rr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = (cand == LastIdx) ? '0 : cand + 1'b1;
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == PtrW'(i)) begin
                sel_we    = req_we_i[i];
                sel_addr  = req_addr_i[i*AW +: AW];
                sel_wdata = req_wdata_i[i*DW +: DW];
            end
        end
    end

    assign rr_next     = (pick == LastIdx) ? '0 : pick + 1'b1;
    assign pick_onehot = {{(N_REQ - 1){1'b0}}, 1'b1} << pick;
    assign timer_inc   = {1'b0, timer_q} + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_q        <= '0;
            timer_q     <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            mem_start_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // Pulse outputs default low so each lasts exactly one cycle.
            mem_start_q <= 1'b0;
            done_q      <= '0;
            err_q       <= '0;
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        gnt_q       <= pick_onehot;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        rr_q        <= rr_next;
                        mem_start_q <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    timer_q <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (mem_done_i) begin
                        if (!mem_we_q) begin
                            rdata_q <= mem_rdata_i;
                        end
                        done_q  <= gnt_q;
                        state_q <= StResp;
                    end else if ((TIMEOUT != 0) && (timer_inc == TimeoutLim)) begin
                        err_q   <= gnt_q;
                        state_q <= StResp;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_inc[TimerW-1:0];
                    end
                end
                StResp: begin
                    gnt_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign mem_start_o = mem_start_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
